// File: rtl/simplebus_pkg.sv
// Shared simplebus types: request record carried through the leader queue and leader FSM states.
package simplebus_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 8;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    typedef enum logic [2:0] {
        IDLE,
        MID,
        LO,
        WR,
        RDWAIT
    } leader_state_e;

endpackage

// File: rtl/simplebus_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module simplebus_req_fifo
    import simplebus_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clock,
    input  logic     resetN,
    input  logic     push_i,
    input  bus_req_t push_data_i,
    input  logic     pop_i,
    output bus_req_t head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    bus_req_t    mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/simplebus_leader_queue.sv
// Simplebus leader front-end: queues core requests and issues them one at a time as
// three address beats plus a data phase, returning a registered completion pulse.
module simplebus_leader_queue
    import simplebus_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              bus_start,
    output logic              bus_read,
    output wire  [7:0]        bus_address,
    inout  wire  [DATA_W-1:0] bus_data,
    inout  wire               bus_data_valid
);

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    leader_state_e     state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    bus_req_t   push_data;
    bus_req_t   head;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       addr_en;
    logic [7:0] addr_val;
    logic       data_en;

    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign push_data = '{write: req_write, addr: req_addr, wdata: req_wdata};

    simplebus_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .resetN      (resetN),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    // Shared lines are released whenever this leader is not the owner of the beat.
    assign bus_address    = addr_en ? addr_val : 8'hzz;
    assign bus_data       = data_en ? head.wdata : {DATA_W{1'bz}};
    assign bus_data_valid = data_en ? 1'b1 : 1'bz;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        bus_start   = 1'b0;
        bus_read    = 1'b0;
        addr_en     = 1'b0;
        addr_val    = '0;
        data_en     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_write_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    bus_start = 1'b1;
                    addr_en   = 1'b1;
                    addr_val  = head.addr[23:16];
                    state_d   = MID;
                end
            end
            MID: begin
                addr_en  = 1'b1;
                addr_val = head.addr[15:8];
                state_d  = LO;
            end
            LO: begin
                addr_en  = 1'b1;
                addr_val = head.addr[7:0];
                bus_read = !head.write;
                cnt_d    = '0;
                state_d  = head.write ? WR : RDWAIT;
            end
            WR: begin
                data_en     = 1'b1;
                pop         = 1'b1;
                rsp_valid_d = 1'b1;
                rsp_write_d = 1'b1;
                state_d     = IDLE;
            end
            RDWAIT: begin
                // Only a driven 1 counts; an undriven or unknown line is not a response.
                if (bus_data_valid == 1'b1) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus_data;
                    pop         = 1'b1;
                    state_d     = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    pop         = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
